// File: rtl/act_tile_scheduler.sv
// Activation tile scheduler: walks slice/row/chunk and issues paired read/write
// burst commands, limited by write-response credits.
module act_tile_scheduler #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BEAT_BYTES      = 32,
  parameter int unsigned MAX_BURST       = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DIM_W           = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_in_surf_stride,
  input  logic [ADDR_W-1:0] cfg_in_line_stride,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_out_surf_stride,
  input  logic [ADDR_W-1:0] cfg_out_line_stride,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_slices,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  input  logic              wr_resp,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CNT_W       = 3 * DIM_W;
  localparam logic [ADDR_W-1:0] CHUNK_BYTES = ADDR_W'(MAX_BURST * BEAT_BYTES);
  localparam logic [DIM_W-1:0]  MB          = DIM_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  MAXO        = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state, state_nx;
  logic              start_q;
  logic              start_take;
  logic [DIM_W-1:0]  w_q, h_q, sl_q;
  // Index 0 walks the read side, index 1 the write side.
  logic [ADDR_W-1:0] base_q [2];
  logic [ADDR_W-1:0] surf_q [2];
  logic [ADDR_W-1:0] line_q [2];
  logic [ADDR_W-1:0] surf_a [2];
  logic [ADDR_W-1:0] line_a [2];
  logic [ADDR_W-1:0] chunk_a[2];
  logic [DIM_W-1:0]  s_c    [2];
  logic [DIM_W-1:0]  h_c    [2];
  logic [DIM_W-1:0]  rem    [2];
  logic [1:0]        all_q;
  logic [1:0]        acc;
  logic [1:0]        last;
  logic [CNT_W-1:0]  rd_issued, wr_issued, resp_cnt;
  logic              resp_ok;
  logic              dims_zero;

  function automatic logic [7:0] len_of(input logic [DIM_W-1:0] r);
    logic [DIM_W-1:0] b;
    b = (r > MB) ? MB : r;
    return 8'(b - DIM_W'(1));
  endfunction

  always_comb begin
    acc[0] = rd_cmd_valid & rd_cmd_ready;
    acc[1] = wr_cmd_valid & wr_cmd_ready;
    for (int unsigned i = 0; i < 2; i++) begin
      last[i] = (rem[i] <= MB) && (h_c[i] == h_q - DIM_W'(1)) &&
                (s_c[i] == sl_q - DIM_W'(1));
    end
    rd_cmd_valid = (state == RUN) && !all_q[0] && ((rd_issued - resp_cnt) < MAXO);
    wr_cmd_valid = (state == RUN) && !all_q[1] && (wr_issued < rd_issued);
    rd_cmd_addr  = rd_cmd_valid ? chunk_a[0] : '0;
    rd_cmd_len   = rd_cmd_valid ? len_of(rem[0]) : '0;
    wr_cmd_addr  = wr_cmd_valid ? chunk_a[1] : '0;
    wr_cmd_len   = wr_cmd_valid ? len_of(rem[1]) : '0;
    resp_ok      = wr_resp && ((state == RUN) || (state == DRAIN)) && (resp_cnt < wr_issued);
    dims_zero    = (w_q == '0) || (h_q == '0) || (sl_q == '0);
    start_take   = start && (state == IDLE) && !start_q;
    busy         = (state != IDLE);
    done         = (state == FIN);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_q) state_nx = dims_zero ? FIN : RUN;
      RUN:     if (all_q[1]) state_nx = DRAIN;
      DRAIN:   if (resp_cnt == wr_issued) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Config is captured on the raw start; the walk begins one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      sl_q      <= '0;
      all_q     <= '0;
      rd_issued <= '0;
      wr_issued <= '0;
      resp_cnt  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        base_q[i]  <= '0;
        surf_q[i]  <= '0;
        line_q[i]  <= '0;
        surf_a[i]  <= '0;
        line_a[i]  <= '0;
        chunk_a[i] <= '0;
        s_c[i]     <= '0;
        h_c[i]     <= '0;
        rem[i]     <= '0;
      end
    end else begin
      start_q <= start_take;
      if (start_take) begin
        w_q       <= cfg_width;
        h_q       <= cfg_height;
        sl_q      <= cfg_slices;
        base_q[0] <= cfg_in_base;
        surf_q[0] <= cfg_in_surf_stride;
        line_q[0] <= cfg_in_line_stride;
        base_q[1] <= cfg_out_base;
        surf_q[1] <= cfg_out_surf_stride;
        line_q[1] <= cfg_out_line_stride;
      end
      if (start_q) begin
        all_q     <= '0;
        rd_issued <= '0;
        wr_issued <= '0;
        resp_cnt  <= '0;
        for (int unsigned i = 0; i < 2; i++) begin
          s_c[i]     <= '0;
          h_c[i]     <= '0;
          rem[i]     <= w_q;
          surf_a[i]  <= base_q[i];
          line_a[i]  <= base_q[i];
          chunk_a[i] <= base_q[i];
        end
      end else begin
        rd_issued <= rd_issued + CNT_W'(acc[0]);
        wr_issued <= wr_issued + CNT_W'(acc[1]);
        resp_cnt  <= resp_cnt + CNT_W'(resp_ok);
        for (int unsigned i = 0; i < 2; i++) begin
          if (acc[i]) begin
            if (last[i]) begin
              all_q[i] <= 1'b1;
            end else if (rem[i] > MB) begin
              rem[i]     <= rem[i] - MB;
              chunk_a[i] <= chunk_a[i] + CHUNK_BYTES;
            end else if (h_c[i] != h_q - DIM_W'(1)) begin
              h_c[i]     <= h_c[i] + DIM_W'(1);
              rem[i]     <= w_q;
              line_a[i]  <= line_a[i] + line_q[i];
              chunk_a[i] <= line_a[i] + line_q[i];
            end else begin
              s_c[i]     <= s_c[i] + DIM_W'(1);
              h_c[i]     <= '0;
              rem[i]     <= w_q;
              surf_a[i]  <= surf_a[i] + surf_q[i];
              line_a[i]  <= surf_a[i] + surf_q[i];
              chunk_a[i] <= surf_a[i] + surf_q[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_act_tile_scheduler.sv
// Self-checking bench for act_tile_scheduler: table-driven jobs plus randomized
// jobs scored against a nested-loop command list, and hand-written corner cases.
module tb_act_tile_scheduler;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DIM_W    = 12;
  localparam int          MB       = 64;
  localparam int          BB       = 32;
  localparam int          MAXO     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       cfg_in_base = '0, cfg_in_surf_stride = '0, cfg_in_line_stride = '0;
  logic [31:0]       cfg_out_base = '0, cfg_out_surf_stride = '0, cfg_out_line_stride = '0;
  logic [11:0]       cfg_width = '0, cfg_height = '0, cfg_slices = '0;
  logic              rd_cmd_valid, rd_cmd_ready = 1'b0;
  logic [31:0]       rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic              wr_cmd_valid, wr_cmd_ready = 1'b0;
  logic [31:0]       wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic              wr_resp = 1'b0;
  logic              busy, done;

  act_tile_scheduler #(
    .ADDR_W(ADDR_W), .BEAT_BYTES(BB), .MAX_BURST(MB),
    .MAX_OUTSTANDING(MAXO), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_base(cfg_in_base), .cfg_in_surf_stride(cfg_in_surf_stride),
    .cfg_in_line_stride(cfg_in_line_stride), .cfg_out_base(cfg_out_base),
    .cfg_out_surf_stride(cfg_out_surf_stride), .cfg_out_line_stride(cfg_out_line_stride),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_slices(cfg_slices),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_resp(wr_resp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] w, h, sl;
    logic [31:0] ib, isf, iln, ob, osf, oln;
    int          n;
    logic [31:0] last_rd;
    logic [7:0]  last_len;
  } job_t;

  typedef struct {
    logic [31:0] ra, wa;
    logic [7:0]  len;
  } cmd_t;

  job_t jobs[5];
  cmd_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference command list straight from the address formula.
  function automatic void build(input job_t j);
    int nc, beats;
    exp_q.delete();
    nc = (int'(j.w) + MB - 1) / MB;
    for (int s = 0; s < int'(j.sl); s++)
      for (int h = 0; h < int'(j.h); h++)
        for (int c = 0; c < nc; c++) begin
          cmd_t e;
          beats = (c == nc - 1) ? int'(j.w) - (nc - 1) * MB : MB;
          e.ra  = j.ib + 32'(s) * j.isf + 32'(h) * j.iln + 32'(c * MB * BB);
          e.wa  = j.ob + 32'(s) * j.osf + 32'(h) * j.oln + 32'(c * MB * BB);
          e.len = 8'(beats - 1);
          exp_q.push_back(e);
        end
  endfunction

  task automatic set_cfg(input job_t j);
    cfg_width = j.w; cfg_height = j.h; cfg_slices = j.sl;
    cfg_in_base = j.ib; cfg_in_surf_stride = j.isf; cfg_in_line_stride = j.iln;
    cfg_out_base = j.ob; cfg_out_surf_stride = j.osf; cfg_out_line_stride = j.oln;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; wr_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_job(input job_t j, input int rdy_pct, input int dmin, input int dmax,
                         input bit chk_tab, input string tag);
    int          cyc = 0, rd_n = 0, wr_n = 0, resp_n = 0, viol = 0, done_n = 0, total;
    bit          fin = 1'b0, pend = 1'b0;
    logic [39:0] held = '0, last_rd = '0;
    int          due[$];
    build(j);
    total = exp_q.size();
    set_cfg(j);
    while (!fin && cyc < 4000) begin
      @(posedge clk); #1;
      if (done) begin
        done_n++;
        if (resp_n != total || rd_n != total) viol++;
      end else if (done_n > 0) begin
        fin = 1'b1;
        chk({tag, "_busy_after_done"}, 64'(busy), 64'(0));
      end
      if (rd_cmd_valid && (rd_n - resp_n) >= MAXO) viol++;
      if (wr_cmd_valid && wr_n >= rd_n) viol++;
      if (pend && (!rd_cmd_valid || {rd_cmd_addr, rd_cmd_len} != held)) viol++;
      start        = (cyc == 0);
      rd_cmd_ready = ($urandom_range(99) < 32'(rdy_pct));
      wr_cmd_ready = ($urandom_range(99) < 32'(rdy_pct));
      wr_resp      = 1'b0;
      for (int k = 0; k < due.size(); k++)
        if (due[k] <= cyc) begin
          wr_resp = 1'b1;
          due.delete(k);
          break;
        end
      #1;
      if (rd_cmd_valid && rd_cmd_ready) begin
        if (rd_n < total)
          chk({tag, "_rd_cmd"}, 64'({rd_cmd_addr, rd_cmd_len}), 64'({exp_q[rd_n].ra, exp_q[rd_n].len}));
        else viol++;
        last_rd = {rd_cmd_addr, rd_cmd_len};
        rd_n++;
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        if (wr_n < total)
          chk({tag, "_wr_cmd"}, 64'({wr_cmd_addr, wr_cmd_len}), 64'({exp_q[wr_n].wa, exp_q[wr_n].len}));
        else viol++;
        wr_n++;
        due.push_back(cyc + int'($urandom_range(dmax, dmin)));
      end
      pend = rd_cmd_valid && !rd_cmd_ready;
      held = {rd_cmd_addr, rd_cmd_len};
      if (wr_resp) resp_n++;
      cyc++;
    end
    start = 1'b0; rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; wr_resp = 1'b0;
    chk({tag, "_finished"}, 64'(fin), 64'(1));
    chk({tag, "_done_pulses"}, 64'(done_n), 64'(1));
    chk({tag, "_protocol_violations"}, 64'(viol), 64'(0));
    if (chk_tab) begin
      chk({tag, "_rd_count"}, 64'(rd_n), 64'(j.n));
      chk({tag, "_wr_count"}, 64'(wr_n), 64'(j.n));
      chk({tag, "_last_rd"}, 64'(last_rd), 64'({j.last_rd, j.last_len}));
    end
  endtask

  initial begin
    int   rd_acc, viol, found, done_at, done_n;
    job_t rj;

    jobs[0] = '{w:197, h:1, sl:3, ib:32'h0, isf:32'd6304, iln:32'd6304,
                ob:32'h0200_0000, osf:32'd6304, oln:32'd6304, n:12, last_rd:32'd18752, last_len:8'd4};
    jobs[1] = '{w:64, h:2, sl:1, ib:32'h1000, isf:32'h1_0000, iln:32'h800,
                ob:32'h8000_0000, osf:32'h1_0000, oln:32'h800, n:2, last_rd:32'h1800, last_len:8'd63};
    jobs[2] = '{w:1, h:1, sl:1, ib:32'hFFFF_FFF0, isf:32'h0, iln:32'h0,
                ob:32'h10, osf:32'h0, oln:32'h0, n:1, last_rd:32'hFFFF_FFF0, last_len:8'd0};
    jobs[3] = '{w:65, h:1, sl:2, ib:32'hFFFF_F000, isf:32'h1000, iln:32'h0,
                ob:32'h4000_0000, osf:32'h1000, oln:32'h0, n:4, last_rd:32'h0000_0800, last_len:8'd0};
    jobs[4] = '{w:128, h:3, sl:2, ib:32'h0, isf:32'd16384, iln:32'd4096,
                ob:32'h9000, osf:32'd16384, oln:32'd4096, n:12, last_rd:32'd26624, last_len:8'd63};

    #1;
    chk("reset_outputs", 64'({rd_cmd_valid, rd_cmd_addr, rd_cmd_len, wr_cmd_valid,
                              wr_cmd_addr, wr_cmd_len, busy, done}), 64'(0));
    do_reset();

    for (int t = 0; t < 5; t++) run_job(jobs[t], 100, 10, 10, 1'b1, $sformatf("tab%0d", t));

    // Credit exhaustion, mid-job start with altered config, then reset after 5th read.
    set_cfg(jobs[0]);
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    pulse_start();
    rd_acc = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_cmd_valid) rd_acc++;
      @(posedge clk); #1;
    end
    chk("credit_rd_count", 64'(rd_acc), 64'(4));
    chk("credit_rd_valid_low", 64'(rd_cmd_valid), 64'(0));
    cfg_in_base = 32'h5555_0000;
    start = 1'b1; wr_resp = 1'b1;
    @(posedge clk); #1 start = 1'b0; wr_resp = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_cmd_valid) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("credit_fifth_rd_seen", 64'(found), 64'(1));
    chk("credit_fifth_rd_cmd", 64'({rd_cmd_addr, rd_cmd_len}), 64'({32'd6304, 8'd63}));
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midreset_outputs", 64'({rd_cmd_valid, rd_cmd_addr, rd_cmd_len, wr_cmd_valid,
                                 wr_cmd_addr, wr_cmd_len, busy, done}), 64'(0));
    do_reset();
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) viol++;
    end
    chk("midreset_no_done", 64'(viol), 64'(0));
    run_job(jobs[0], 100, 10, 10, 1'b1, "after_reset");

    // Read backpressure: command must hold and no write may lead it.
    set_cfg(jobs[0]);
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 5 && !rd_cmd_valid; k++) begin
      @(posedge clk); #1;
    end
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      if (!rd_cmd_valid || rd_cmd_addr != 32'h0 || rd_cmd_len != 8'd63) viol++;
      if (wr_cmd_valid) viol++;
      @(posedge clk); #1;
    end
    chk("stall_hold", 64'(viol), 64'(0));
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b0;
    @(posedge clk); #1 rd_cmd_ready = 1'b0;
    chk("stall_wr_after_rd", 64'({wr_cmd_valid, wr_cmd_addr, wr_cmd_len}),
        64'({1'b1, 32'h0200_0000, 8'd63}));
    do_reset();

    // Zero width: no commands, single done two cycles after start.
    rj = jobs[0];
    rj.w = '0;
    set_cfg(rj);
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    viol = 0; done_at = -1; done_n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1 start = 1'b0;
      if (rd_cmd_valid || wr_cmd_valid) viol++;
      if (done) begin done_n++; done_at = k; end
    end
    chk("zero_w_no_cmds", 64'(viol), 64'(0));
    chk("zero_w_done_count", 64'(done_n), 64'(1));
    chk("zero_w_done_cycle", 64'(done_at), 64'(2));
    chk("zero_w_busy_idle", 64'(busy), 64'(0));
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;

    // Randomized jobs against the reference list.
    for (int t = 0; t < 6; t++) begin
      rj.w   = 12'($urandom_range(150, 1));
      rj.h   = 12'($urandom_range(3, 1));
      rj.sl  = 12'($urandom_range(3, 1));
      rj.ib  = $urandom; rj.isf = $urandom; rj.iln = $urandom;
      rj.ob  = $urandom; rj.osf = $urandom; rj.oln = $urandom;
      rj.n = 0; rj.last_rd = '0; rj.last_len = '0;
      run_job(rj, int'($urandom_range(90, 30)), 1, 12, 1'b0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/act_tile_scheduler.md
Name: act_tile_scheduler

Overview:
- Sequences the activation datapath inside the accelerator wrapper.
- On a CSR start pulse it walks the feature map: channel slice (Tout channels per beat), then row, then burst chunk within the row.
- Issues AXI-style read burst commands for input tiles and matching write burst commands for output tiles.
- Bounds bursts in flight by write-response credits and pulses done once the last write response returns.

Parameters:
- ADDR_W, 32, address width; address arithmetic is modulo 2^ADDR_W.
- BEAT_BYTES, 32, bytes per data beat (MAX_DAT_DW*Tout/8).
- MAX_BURST, 64, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum read bursts issued whose write response has not returned.
- DIM_W, 12, width of width/height/slice count fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse from CSR
- cfg_in_base  in  ADDR_W  input base address
- cfg_in_surf_stride  in  ADDR_W  input surface (slice) stride, bytes
- cfg_in_line_stride  in  ADDR_W  input line stride, bytes
- cfg_out_base  in  ADDR_W  output base address
- cfg_out_surf_stride  in  ADDR_W  output surface stride, bytes
- cfg_out_line_stride  in  ADDR_W  output line stride, bytes
- cfg_width  in  DIM_W  pixels per row (= beats per row per slice)
- cfg_height  in  DIM_W  rows
- cfg_slices  in  DIM_W  channel slices, ceil(CH/Tout)
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read command accept
- rd_cmd_addr  out  ADDR_W  read burst start address
- rd_cmd_len  out  8  read beats-1
- wr_cmd_valid  out  1  write command valid
- wr_cmd_ready  in  1  write command accept
- wr_cmd_addr  out  ADDR_W  write burst start address
- wr_cmd_len  out  8  write beats-1
- wr_resp  in  1  one write burst completed (BVALID&BREADY)
- busy  out  1  job active
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; counters 0; state IDLE.
- States:
  - IDLE: start -> latch all cfg_*, go to RUN. If cfg_width, cfg_height or cfg_slices is 0, go to FIN instead.
  - RUN: issue commands. When every read and write command has been issued, go to DRAIN.
  - DRAIN: wait until resp_cnt equals the total burst count, then go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and FIN.
- Walk order: slice s (outer), row h, chunk c (inner).
- Chunks per row: NC=ceil(W/MAX_BURST). Chunk c has MAX_BURST beats, except the last, which has W-(NC-1)*MAX_BURST beats. len = beats-1.
- Addresses:
  - rd addr = in_base + s*in_surf + h*in_line + c*MAX_BURST*BEAT_BYTES.
  - wr addr uses the out_* equivalents.
  - Generate with incremental adders, no multipliers.
- Total bursts = slices*H*NC.
- Handshake: a command is transferred on valid&ready.
  - valid, addr and len hold stable until accepted.
  - The next command is presented the cycle after acceptance; zero-bubble back-to-back is not required.
- Read gating: rd_cmd_valid only when (rd_issued - resp_cnt) < MAX_OUTSTANDING.
- Write gating: wr_cmd_valid only when wr_issued < rd_issued. Write command k never precedes read command k.
- Simultaneous accept and wr_resp in one cycle: both counters update; the credit check uses registered counts, so a freed credit is usable next cycle.
- wr_resp while idle, or beyond the total burst count: ignored, no counter change.
- start while busy: ignored; the latched config is unaffected.
- Changing cfg_* after start has no effect on the running job.
- Reset mid-job: immediate return to IDLE, outputs 0, no done pulse.

Test Plan:
- W=197, H=1, slices=3, in_base=0, in_line=in_surf=6304, out_base=0x2000000 (same strides), always-ready, wr_resp 10 cycles after each write -> 12 read cmds.
  - Per slice: addrs +0, +2048, +4096, +6144 with len 63, 63, 63, 4.
  - Slice 1 starts at 6304; write addrs are offset by 0x2000000.
  - done after the 12th wr_resp.
- Same config, wr_resp withheld -> exactly 4 read cmds issued, then rd_cmd_valid stays 0. One wr_resp -> the 5th read issues 1+ cycle later.
- rd_cmd_ready held low 20 cycles -> rd_cmd_addr and rd_cmd_len stable throughout; no write cmd appears before the first read is accepted.
- cfg_width=0 -> no commands; done=1 exactly once, 2 cycles after start; busy returns to 0.
- start pulsed again mid-job, and rst_n asserted after the 5th read -> second start ignored. After reset: outputs 0, no done; a fresh start runs the full 12-burst sequence correctly.
- W=64, H=2, slices=1 -> 2 read cmds of len 63 at base and base+in_line; boundary with no partial chunk.
